// File: rtl/serial_transmitter.sv
// Parallel-to-serial asynchronous transmitter.
// Sends one frame per accepted load: a start bit (0), DATA_BITS data bits
// LSB first, and a stop bit (1). Each bit is held for SAMPLES_PER_BIT clocks,
// so the line lines up with the receiver's bit-sample counter.
//
// Handshake: load is a request that is accepted on a rising clk edge only
// while busy=0. data_in is sampled on that same edge and ignored for the rest
// of the frame. charSent pulses for one cycle, on the cycle busy falls.
module serial_transmitter #(
  parameter int SAMPLES_PER_BIT = 16,
  parameter int DATA_BITS       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 load,
  output logic                 data_out,
  output logic                 busy,
  output logic                 charSent,
  output logic [1:0]           dbg_state
);

  localparam int CW = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] BSC_MAX = CW'(SAMPLES_PER_BIT - 1);
  localparam logic [BW-1:0] BIC_MAX = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        bsc, bsc_n;     // bit-sample counter
  logic [BW-1:0]        bic, bic_n;     // bit-index counter
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 dout_n;
  logic                 sent_n;
  logic                 bit_end;

  assign bit_end   = (bsc == BSC_MAX);
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Next-state and next-output logic; the line value is decided here and
  // registered so data_out never sees a combinational path from the inputs.
  always_comb begin
    state_n = state;
    bsc_n   = bsc;
    bic_n   = bic;
    shift_n = shift;
    dout_n  = data_out;
    sent_n  = 1'b0;
    case (state)
      IDLE: begin
        dout_n = 1'b1;
        bsc_n  = '0;
        bic_n  = '0;
        if (load) begin
          shift_n = data_in;
          state_n = START;
          dout_n  = 1'b0;
        end
      end
      START: begin
        bsc_n = bit_end ? '0 : bsc + CW'(1);
        if (bit_end) begin
          state_n = DATA;
          dout_n  = shift[0];
        end
      end
      DATA: begin
        bsc_n = bit_end ? '0 : bsc + CW'(1);
        if (bit_end) begin
          if (bic == BIC_MAX) begin
            state_n = STOP;
            dout_n  = 1'b1;
          end else begin
            shift_n = shift >> 1;
            bic_n   = bic + BW'(1);
            dout_n  = shift_n[0];
          end
        end
      end
      STOP: begin
        bsc_n  = bit_end ? '0 : bsc + CW'(1);
        dout_n = 1'b1;
        if (bit_end) begin
          state_n = IDLE;
          sent_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        bsc_n   = '0;
        bic_n   = '0;
        dout_n  = 1'b1;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bsc      <= '0;
      bic      <= '0;
      shift    <= '0;
      data_out <= 1'b1;
      charSent <= 1'b0;
    end else begin
      state    <= state_n;
      bsc      <= bsc_n;
      bic      <= bic_n;
      shift    <= shift_n;
      data_out <= dout_n;
      charSent <= sent_n;
    end
  end

endmodule

// File: doc/serial_transmitter.md
Name: serial_transmitter

Overview:
- Parallel-to-serial asynchronous transmitter; the transmit-side counterpart of the receiving path.
- Accepts one character per load strobe and shifts out a 10-bit frame: start bit (0), DATA_BITS data bits LSB first, stop bit (1).
- Each bit is held for SAMPLES_PER_BIT clk cycles, matching the receiver's bit-sample counter timing, so the output can drive the receive input directly.
- Sits between the processor's output port and the serial line.

Parameters:
- SAMPLES_PER_BIT, 16, clk cycles per serial bit; must be 2..256.
- DATA_BITS, 8, data bits per frame. Frame length is DATA_BITS+2 bits.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  DATA_BITS  character to send; sampled only on an accepted load.
- load  input  1  request to send data_in; accepted only when busy=0.
- data_out  output  1  serial line, registered; idles high.
- busy  output  1  high while a frame is in progress.
- charSent  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - Outputs: data_out=1, busy=0, charSent=0.
  - Internal: state=IDLE, bit-sample counter BSC=0, bit-index counter BIC=0, shift register cleared.
  - A partially sent frame is abandoned; no charSent pulse is generated.
- States: IDLE, START, DATA, STOP. Only one state is active at a time; any illegal encoding returns to IDLE.
- IDLE:
  - data_out=1, busy=0.
  - On a rising edge with load=1: latch data_in into the shift register, BSC=0, BIC=0, go to START.
  - data_out=0 and busy=1 from that same edge.
- BSC counts 0..SAMPLES_PER_BIT-1 in every non-IDLE state. The bit transition occurs on the edge where BSC=SAMPLES_PER_BIT-1; BSC then wraps to 0.
- START: data_out=0 for SAMPLES_PER_BIT cycles, then go to DATA with data_out=shift[0].
- DATA:
  - At each bit boundary: shift right and increment BIC.
  - After bit DATA_BITS-1 completes (BIC=DATA_BITS-1 at the boundary): go to STOP with data_out=1.
- STOP:
  - data_out=1 for SAMPLES_PER_BIT cycles.
  - At the boundary: go to IDLE, busy=0, charSent=1 for exactly that one cycle.
- Frame duration: (DATA_BITS+2)*SAMPLES_PER_BIT cycles from the load edge to busy falling (160 at defaults).
- load while busy=1 is ignored; the held data is unaffected by data_in changes.
- A load held high through the end of a frame starts the next frame on the first IDLE edge. The line is high for exactly 1 cycle between back-to-back frames.
- load and reset together: reset wins.
- data_out is driven from a flop (no combinational path from load or data_in).

Test Plan:
- Reset then 50 idle cycles -> data_out=1, busy=0, charSent=0 throughout.
- load=1 for 1 cycle with data_in=8'h41 -> data_out carries bits 0,1,0,0,0,0,0,1,0,1, each exactly 16 cycles. busy is high for 160 cycles; charSent pulses once, on the cycle busy falls.
- data_in=8'h00, then 8'hFF -> 9 low bits (144 cycles) then stop high; start low then 9 high bits. Frame length 160 each.
- Load 8'h55, then pulse load=1 with data_in=8'hAA at cycle 40 -> second load ignored; line still carries 8'h55 and exactly one charSent pulse.
- load held high with data_in=8'hC3 -> consecutive identical frames with a 1-cycle high gap; charSent every 161 cycles.
- Assert reset at cycle 70 of a frame -> data_out=1 and busy=0 immediately (before the next edge), no charSent. A later load of 8'h5A produces a clean full frame.
- Loopback into the receiving block for 8'h00..8'hFF -> every character is received intact, with charReceived once per charSent.
